rsa_modexp_sequencer: RTL and testbench
=======================================

Name: rsa_modexp_sequencer

Overview:
Control FSM for left-to-right binary modular exponentiation (square-and-multiply) in the Montgomery domain. It owns no wide data. It sequences one shared external Montgomery multiplier and tells the wrapper-side datapath which operands to route and which register to load. It sits between the command FSM (start/done) and the multiplier/operand-register datapath.

Parameters:
EXP_WIDTH, 1024, maximum exponent width in bits
CNT_W, 10, log2(EXP_WIDTH); width of the bit index

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; accepted only in IDLE
abort  input  1  cancel the current operation; ignored in IDLE
exponent  input  EXP_WIDTH  exponent; sampled when start is accepted
exp_len  input  CNT_W+1  number of significant exponent bits (1..EXP_WIDTH); sampled when start is accepted
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle completion pulse
error  output  1  high together with done when exp_len was invalid
acc_init  output  1  load accumulator with Montgomery one (R mod N)
mul_start  output  1  one-cycle pulse to the multiplier
mul_op  output  2  operand select: 0 = x*R2 (to Montgomery domain), 1 = acc*acc, 2 = acc*xm, 3 = acc*1 (from Montgomery domain)
mul_done  input  1  one-cycle result-valid pulse from the multiplier
xm_we  output  1  write multiplier result into the xm register
acc_we  output  1  write multiplier result into the accumulator
bit_idx  output  CNT_W  exponent bit currently being processed
state  output  4  FSM state, for the LEDs

Behaviour:
- Reset (asynchronous, takes effect immediately): state=IDLE, bit_idx=0, captured exponent=0; all outputs 0.
- States (4-bit encoding): IDLE=0, INIT=1, PRE_ISSUE=2, PRE_WAIT=3, SQR_ISSUE=4, SQR_WAIT=5, MUL_ISSUE=6, MUL_WAIT=7, POST_ISSUE=8, POST_WAIT=9, DONE=10. Unused encodings go to IDLE.
- IDLE, start=1:
  - exp_len==0 or exp_len>EXP_WIDTH -> DONE with the error flag set; no multiplier activity.
  - Otherwise capture exponent, set bit_idx=exp_len-1, go to INIT.
- INIT: acc_init=1 for exactly this cycle -> PRE_ISSUE.
- *_ISSUE states: mul_start=1 for exactly one cycle, then the matching *_WAIT state.
- mul_op is driven combinationally from state and is stable through each ISSUE/WAIT pair: PRE=0, SQR=1, MUL=2, POST=3. In IDLE, INIT and DONE, mul_op=0.
- *_WAIT states: hold until mul_done=1. In that same cycle, xm_we=1 (PRE) or acc_we=1 (SQR/MUL/POST), combinationally.
- mul_done is ignored in every state other than a WAIT state, including the ISSUE cycle. The multiplier latency must be >=1.
- Transitions on mul_done:
  - PRE_WAIT -> SQR_ISSUE.
  - SQR_WAIT -> MUL_ISSUE if exponent[bit_idx]=1, else the bit-step rule.
  - MUL_WAIT -> bit-step rule.
  - POST_WAIT -> DONE.
- Bit-step rule: bit_idx==0 -> POST_ISSUE; else decrement bit_idx and go to SQR_ISSUE. bit_idx never wraps below 0.
- DONE: done=1 for one cycle, error=1 only on the invalid-length path -> IDLE.
- Multiplier operation count per run: 2 + exp_len + popcount(exponent[exp_len-1:0]).
- start while busy: ignored; the in-flight operation is unaffected.
- abort=1 in any non-IDLE state: next state IDLE, no done pulse, no further mul_start. Abort has priority over mul_done in the same cycle, and no xm_we/acc_we is asserted that cycle.
- Bits of exponent at or above exp_len are ignored.
- Reset mid-operation: immediate return to IDLE; a later start runs normally.
- Outputs carry no extra pipeline delay; all pulses are derived from the current state.

Test Plan:
- exponent=4'b1011, exp_len=4, multiplier model with 3-cycle latency -> 9 mul_start pulses with mul_op sequence 0,1,2,1,1,2,1,2,3. Exactly one xm_we and eight acc_we. done pulses once, one cycle after the POST acc_we; error=0.
- exponent=1, exp_len=1 -> ops 0,1,2,3; bit_idx stays 0; done one cycle after the final acc_we.
- exp_len=0, and separately exp_len=EXP_WIDTH+1, start at cycle 0 -> DONE at cycle 1 with done=1 and error=1; no mul_start, acc_init or busy after cycle 1.
- Stray mul_done during SQR_ISSUE and during IDLE; start pulsed while in SQR_WAIT -> no state change, no write enables, sequence unchanged.
- abort during MUL_WAIT in the same cycle as mul_done -> IDLE next cycle, acc_we=0, no done. A following start with exponent=2'b10, exp_len=2 completes with ops 0,1,2,1,3.
- reset asserted mid SQR_WAIT (asynchronously, between clock edges) -> busy, mul_start and state drop to 0 before the next edge. exp_len=EXP_WIDTH with an all-ones exponent then gives 2*EXP_WIDTH+2 multiplier operations.

Source files
------------

// File: rtl/rsa_modexp_sequencer.sv
// rsa_modexp_sequencer
// Control FSM for left-to-right square-and-multiply modular exponentiation in
// the Montgomery domain. Holds only the exponent and bit index; it steers one
// shared external Montgomery multiplier and the operand/result registers that
// live in the wrapper datapath.
module rsa_modexp_sequencer #(
  parameter int EXP_WIDTH = 1024,
  parameter int CNT_W     = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [CNT_W:0]       exp_len,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 acc_init,
  output logic                 mul_start,
  output logic [1:0]           mul_op,
  input  logic                 mul_done,
  output logic                 xm_we,
  output logic                 acc_we,
  output logic [CNT_W-1:0]     bit_idx,
  output logic [3:0]           state
);

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_INIT       = 4'd1,
    ST_PRE_ISSUE  = 4'd2,
    ST_PRE_WAIT   = 4'd3,
    ST_SQR_ISSUE  = 4'd4,
    ST_SQR_WAIT   = 4'd5,
    ST_MUL_ISSUE  = 4'd6,
    ST_MUL_WAIT   = 4'd7,
    ST_POST_ISSUE = 4'd8,
    ST_POST_WAIT  = 4'd9,
    ST_DONE       = 4'd10
  } state_t;

  localparam logic [CNT_W:0] EXP_MAX = (CNT_W + 1)'(EXP_WIDTH);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       bit_idx_q, bit_idx_d;
  logic [EXP_WIDTH-1:0]   exp_q, exp_d;
  logic                   err_q, err_d;

  logic                   len_bad_s;
  logic                   last_bit_s;
  logic                   cur_bit_s;
  state_t                 step_state_s;
  logic [CNT_W-1:0]       step_idx_s;

  assign len_bad_s  = (exp_len == {(CNT_W + 1){1'b0}}) || (exp_len > EXP_MAX);
  assign last_bit_s = (bit_idx_q == {CNT_W{1'b0}});
  assign cur_bit_s  = exp_q[bit_idx_q];

  // Bit-step: move to the next lower exponent bit, or finish with the out-of-domain multiply
  always_comb begin
    if (last_bit_s) begin
      step_state_s = ST_POST_ISSUE;
      step_idx_s   = bit_idx_q;
    end else begin
      step_state_s = ST_SQR_ISSUE;
      step_idx_s   = bit_idx_q - {{(CNT_W - 1){1'b0}}, 1'b1};
    end
  end

  // Next-state logic; abort outranks everything once an operation is in flight
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    exp_d     = exp_q;
    err_d     = err_q;
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!start) begin
            state_d = ST_IDLE;
          end else if (len_bad_s) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else begin
            state_d   = ST_INIT;
            exp_d     = exponent;
            bit_idx_d = exp_len[CNT_W-1:0] - {{(CNT_W - 1){1'b0}}, 1'b1};
            err_d     = 1'b0;
          end
        end
        ST_INIT:       state_d = ST_PRE_ISSUE;
        ST_PRE_ISSUE:  state_d = ST_PRE_WAIT;
        ST_PRE_WAIT: begin
          if (mul_done) begin
            state_d = ST_SQR_ISSUE;
          end else begin
            state_d = ST_PRE_WAIT;
          end
        end
        ST_SQR_ISSUE:  state_d = ST_SQR_WAIT;
        ST_SQR_WAIT: begin
          if (!mul_done) begin
            state_d = ST_SQR_WAIT;
          end else if (cur_bit_s) begin
            state_d = ST_MUL_ISSUE;
          end else begin
            state_d   = step_state_s;
            bit_idx_d = step_idx_s;
          end
        end
        ST_MUL_ISSUE:  state_d = ST_MUL_WAIT;
        ST_MUL_WAIT: begin
          if (mul_done) begin
            state_d   = step_state_s;
            bit_idx_d = step_idx_s;
          end else begin
            state_d = ST_MUL_WAIT;
          end
        end
        ST_POST_ISSUE: state_d = ST_POST_WAIT;
        ST_POST_WAIT: begin
          if (mul_done) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_POST_WAIT;
          end
        end
        ST_DONE:       state_d = ST_IDLE;
        default:       state_d = ST_IDLE;
      endcase
    end
  end

  // State, bit index, captured exponent and error flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_idx_q <= {CNT_W{1'b0}};
      exp_q     <= {EXP_WIDTH{1'b0}};
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      exp_q     <= exp_d;
      err_q     <= err_d;
    end
  end

  // Datapath controls decoded from the current state; write enables gated by abort
  always_comb begin
    mul_start = 1'b0;
    mul_op    = 2'd0;
    xm_we     = 1'b0;
    acc_we    = 1'b0;
    case (state_q)
      ST_PRE_ISSUE:  mul_start = 1'b1;
      ST_PRE_WAIT:   xm_we     = mul_done & ~abort;
      ST_SQR_ISSUE: begin
        mul_start = 1'b1;
        mul_op    = 2'd1;
      end
      ST_SQR_WAIT: begin
        mul_op = 2'd1;
        acc_we = mul_done & ~abort;
      end
      ST_MUL_ISSUE: begin
        mul_start = 1'b1;
        mul_op    = 2'd2;
      end
      ST_MUL_WAIT: begin
        mul_op = 2'd2;
        acc_we = mul_done & ~abort;
      end
      ST_POST_ISSUE: begin
        mul_start = 1'b1;
        mul_op    = 2'd3;
      end
      ST_POST_WAIT: begin
        mul_op = 2'd3;
        acc_we = mul_done & ~abort;
      end
      default:       mul_op = 2'd0;
    endcase
  end

  assign busy     = (state_q != ST_IDLE);
  assign acc_init = (state_q == ST_INIT);
  assign done     = (state_q == ST_DONE);
  assign error    = (state_q == ST_DONE) & err_q;
  assign bit_idx  = bit_idx_q;
  assign state    = state_q;

endmodule

// File: tb/tb_rsa_modexp_sequencer.sv
// Self-checking bench for rsa_modexp_sequencer: a latency-3 multiplier model,
// a scoreboard of expected mul_op values, and one task per scenario.
module tb_rsa_modexp_sequencer;
  localparam int EXP_WIDTH = 1024;
  localparam int CNT_W     = 10;
  localparam int LAT       = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start, abort;
  logic [EXP_WIDTH-1:0] exponent;
  logic [CNT_W:0]       exp_len;
  logic                 busy, done, error, acc_init, mul_start, xm_we, acc_we;
  logic [1:0]           mul_op;
  logic                 mul_done;
  logic [CNT_W-1:0]     bit_idx;
  logic [3:0]           state;
  logic                 mdone_model = 1'b0;
  logic                 mdone_force = 1'b0;

  assign mul_done = mdone_model | mdone_force;

  int n_checks = 0, n_fail = 0;
  int q_ops[$];
  int n_start, n_xm, n_acc, n_done, n_err, n_init, n_busy, n_bitnz;
  int cyc = 0, start_cyc = 0, last_acc_cyc = 0, done_cyc = 0;
  int mcnt = 0;

  rsa_modexp_sequencer #(.EXP_WIDTH(EXP_WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .exponent(exponent), .exp_len(exp_len), .busy(busy), .done(done),
    .error(error), .acc_init(acc_init), .mul_start(mul_start), .mul_op(mul_op),
    .mul_done(mul_done), .xm_we(xm_we), .acc_we(acc_we), .bit_idx(bit_idx),
    .state(state)
  );

  always #5 clk = ~clk;

  // Cycle counter
  always @(posedge clk) cyc++;

  // Multiplier model: one-cycle result pulse in the LAT-th cycle after the issue cycle
  always @(posedge clk) begin
    logic issued;
    issued = mul_start;
    #1;
    if (reset) mcnt = 0;
    else if (issued) mcnt = LAT;
    else if (mcnt > 0) mcnt--;
    mdone_model = (mcnt == 1);
  end

  // Monitor: scoreboard pop on every mul_start, event counters for the tasks
  always @(negedge clk) begin
    int exp_op;
    if (mul_start) begin
      n_start++;
      n_checks++;
      if (q_ops.size() == 0) begin
        n_fail++;
        $display("FAIL op_seq: unexpected mul_start with mul_op=%0d, nothing expected", mul_op);
      end else begin
        exp_op = q_ops.pop_front();
        if (mul_op !== exp_op[1:0]) begin
          n_fail++;
          $display("FAIL op_seq: op #%0d got mul_op=%0d expected %0d", n_start, mul_op, exp_op);
        end
      end
    end
    if (xm_we) n_xm++;
    if (acc_we) begin n_acc++; last_acc_cyc = cyc; end
    if (done) begin n_done++; done_cyc = cyc; end
    if (error) n_err++;
    if (acc_init) n_init++;
    if (busy) n_busy++;
    if (busy && bit_idx !== '0) n_bitnz++;
  end

  task automatic clear_stats();
    q_ops.delete();
    n_start = 0; n_xm = 0; n_acc = 0; n_done = 0; n_err = 0;
    n_init = 0; n_busy = 0; n_bitnz = 0;
  endtask

  // Reference: PRE, then per bit (MSB first) SQR and MUL when the bit is 1, then POST
  task automatic push_ops(input logic [EXP_WIDTH-1:0] e, input logic [CNT_W:0] l);
    q_ops.push_back(0);
    for (int i = int'(l) - 1; i >= 0; i--) begin
      q_ops.push_back(1);
      if (e[i]) q_ops.push_back(2);
    end
    q_ops.push_back(3);
  endtask

  task automatic do_start(input logic [EXP_WIDTH-1:0] e, input logic [CNT_W:0] l);
    @(posedge clk); #1;
    exponent = e; exp_len = l; start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (busy === 1'b1 && k < budget) begin @(posedge clk); #1; k++; end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_timeout: busy=%b after %0d cycles, expected 0", name, busy, k);
    end
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget, input string name);
    int k = 0;
    while (state !== s && k < budget) begin @(posedge clk); #2; k++; end
    n_checks++;
    if (state !== s) begin
      n_fail++; $display("FAIL %s_timeout: state=%0d expected %0d", name, state, s);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; exponent = '0; exp_len = '0;
    #2;
    n_checks++;
    if ({busy, done, error, acc_init, mul_start, xm_we, acc_we} !== 7'b0 ||
        mul_op !== 2'd0 || bit_idx !== '0 || state !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b init=%b ms=%b xw=%b aw=%b op=%0d idx=%0d st=%0d expected all 0",
               busy, done, error, acc_init, mul_start, xm_we, acc_we, mul_op, bit_idx, state);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (state !== 4'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: state=%0d busy=%b expected 0/0", state, busy);
    end
  endtask

  task automatic test_basic();
    logic [EXP_WIDTH-1:0] e;
    e = '0; e[7:0] = 8'hFB;  // low nibble 1011, upper bits beyond exp_len set on purpose
    clear_stats();
    push_ops(e, 11'd4);
    do_start(e, 11'd4);
    wait_idle(200, "basic");
    n_checks++;
    if (n_start != 9 || q_ops.size() != 0) begin
      n_fail++; $display("FAIL basic_ops: starts=%0d left=%0d expected 9/0", n_start, q_ops.size());
    end
    n_checks++;
    if (n_xm != 1 || n_acc != 8 || n_init != 1) begin
      n_fail++; $display("FAIL basic_we: xm=%0d acc=%0d init=%0d expected 1/8/1", n_xm, n_acc, n_init);
    end
    n_checks++;
    if (n_done != 1 || n_err != 0 || done_cyc != last_acc_cyc + 1) begin
      n_fail++; $display("FAIL basic_done: done=%0d err=%0d done_cyc=%0d expected 1/0/%0d",
                         n_done, n_err, done_cyc, last_acc_cyc + 1);
    end
  endtask

  task automatic test_single_bit();
    logic [EXP_WIDTH-1:0] e;
    e = '0; e[0] = 1'b1;
    clear_stats();
    push_ops(e, 11'd1);
    do_start(e, 11'd1);
    wait_idle(100, "single");
    n_checks++;
    if (n_start != 4 || q_ops.size() != 0 || n_bitnz != 0) begin
      n_fail++; $display("FAIL single_ops: starts=%0d left=%0d nonzero_idx=%0d expected 4/0/0",
                         n_start, q_ops.size(), n_bitnz);
    end
    n_checks++;
    if (n_done != 1 || n_err != 0 || done_cyc != last_acc_cyc + 1) begin
      n_fail++; $display("FAIL single_done: done=%0d err=%0d done_cyc=%0d expected 1/0/%0d",
                         n_done, n_err, done_cyc, last_acc_cyc + 1);
    end
  endtask

  task automatic test_invalid_len(input logic [CNT_W:0] l);
    logic [EXP_WIDTH-1:0] e;
    e = '1;
    clear_stats();
    do_start(e, l);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (n_done != 1 || n_err != 1 || done_cyc != start_cyc + 1) begin
      n_fail++; $display("FAIL invalid_done len=%0d: done=%0d err=%0d done_cyc=%0d expected 1/1/%0d",
                         l, n_done, n_err, done_cyc, start_cyc + 1);
    end
    n_checks++;
    if (n_start != 0 || n_init != 0 || n_busy != 1) begin
      n_fail++; $display("FAIL invalid_quiet len=%0d: starts=%0d init=%0d busy_cycles=%0d expected 0/0/1",
                         l, n_start, n_init, n_busy);
    end
  endtask

  task automatic test_stray_inputs();
    logic [EXP_WIDTH-1:0] e;
    e = '0; e[2:0] = 3'b101;
    clear_stats();
    push_ops(e, 11'd3);
    @(posedge clk); #1;
    mdone_force = 1'b1; #1;
    n_checks++;
    if (xm_we !== 1'b0 || acc_we !== 1'b0) begin
      n_fail++; $display("FAIL stray_idle_we: xm_we=%b acc_we=%b expected 0/0", xm_we, acc_we);
    end
    @(posedge clk); #1;
    mdone_force = 1'b0;
    n_checks++;
    if (state !== 4'd0) begin
      n_fail++; $display("FAIL stray_idle_state: state=%0d expected 0", state);
    end
    do_start(e, 11'd3);
    wait_state(4'd4, 50, "stray_sqr_issue");
    mdone_force = 1'b1; #1;
    n_checks++;
    if (xm_we !== 1'b0 || acc_we !== 1'b0) begin
      n_fail++; $display("FAIL stray_issue_we: xm_we=%b acc_we=%b expected 0/0", xm_we, acc_we);
    end
    @(posedge clk); #1;
    mdone_force = 1'b0;
    exponent = '1; exp_len = 11'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (state !== 4'd5) begin
      n_fail++; $display("FAIL stray_busy_start: state=%0d expected 5", state);
    end
    wait_idle(200, "stray");
    n_checks++;
    if (n_start != 7 || q_ops.size() != 0 || n_xm != 1 || n_acc != 6 || n_done != 1) begin
      n_fail++; $display("FAIL stray_seq: starts=%0d left=%0d xm=%0d acc=%0d done=%0d expected 7/0/1/6/1",
                         n_start, q_ops.size(), n_xm, n_acc, n_done);
    end
  endtask

  task automatic test_abort();
    logic [EXP_WIDTH-1:0] e;
    int k;
    e = '0; e[3:0] = 4'b1011;
    clear_stats();
    q_ops.push_back(0); q_ops.push_back(1); q_ops.push_back(2);
    do_start(e, 11'd4);
    wait_state(4'd7, 50, "abort_mul_wait");
    k = 0;
    while (mul_done !== 1'b1 && k < 20) begin @(posedge clk); #2; k++; end
    n_checks++;
    if (mul_done !== 1'b1) begin
      n_fail++; $display("FAIL abort_mul_done_timeout: mul_done=%b expected 1", mul_done);
    end
    abort = 1'b1; #1;
    n_checks++;
    if (acc_we !== 1'b0 || xm_we !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_we: acc_we=%b xm_we=%b done=%b expected 0/0/0", acc_we, xm_we, done);
    end
    @(posedge clk); #1;
    abort = 1'b0;
    n_checks++;
    if (state !== 4'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: state=%0d busy=%b expected 0/0", state, busy);
    end
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (n_done != 0 || n_start != 3 || q_ops.size() != 0) begin
      n_fail++; $display("FAIL abort_quiet: done=%0d starts=%0d left=%0d expected 0/3/0",
                         n_done, n_start, q_ops.size());
    end
    e = '0; e[1:0] = 2'b10;
    clear_stats();
    push_ops(e, 11'd2);
    do_start(e, 11'd2);
    wait_idle(100, "after_abort");
    n_checks++;
    if (n_start != 5 || q_ops.size() != 0 || n_done != 1 || n_err != 0) begin
      n_fail++; $display("FAIL after_abort_run: starts=%0d left=%0d done=%0d err=%0d expected 5/0/1/0",
                         n_start, q_ops.size(), n_done, n_err);
    end
  endtask

  task automatic test_reset_mid_and_full_width();
    logic [EXP_WIDTH-1:0] e;
    e = '0; e[3:0] = 4'b1011;
    clear_stats();
    q_ops.push_back(0); q_ops.push_back(1);
    do_start(e, 11'd4);
    wait_state(4'd5, 50, "reset_sqr_wait");
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || mul_start !== 1'b0 || state !== 4'd0 || bit_idx !== '0) begin
      n_fail++; $display("FAIL reset_async: busy=%b mul_start=%b state=%0d bit_idx=%0d expected 0/0/0/0",
                         busy, mul_start, state, bit_idx);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if (n_start != 2 || q_ops.size() != 0) begin
      n_fail++; $display("FAIL reset_partial: starts=%0d left=%0d expected 2/0", n_start, q_ops.size());
    end
    e = '1;
    clear_stats();
    push_ops(e, 11'd1024);
    do_start(e, 11'd1024);
    wait_idle(12000, "full_width");
    n_checks++;
    if (n_start != 2 * EXP_WIDTH + 2 || q_ops.size() != 0) begin
      n_fail++; $display("FAIL full_width_ops: starts=%0d left=%0d expected %0d/0",
                         n_start, q_ops.size(), 2 * EXP_WIDTH + 2);
    end
    n_checks++;
    if (n_xm != 1 || n_acc != 2 * EXP_WIDTH + 1 || n_done != 1 || n_err != 0) begin
      n_fail++; $display("FAIL full_width_we: xm=%0d acc=%0d done=%0d err=%0d expected 1/%0d/1/0",
                         n_xm, n_acc, n_done, n_err, 2 * EXP_WIDTH + 1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_bit();
    test_invalid_len(11'd0);
    test_invalid_len(11'd1025);
    test_stray_inputs();
    test_abort();
    test_reset_mid_and_full_width();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
